// File: rtl/lsu_ctrl.sv
// Purpose: load/store control between execute and memory; checks alignment, issues one
//          word-aligned masked request, extends load data and returns it to writeback.
// Latency: accept in cycle N -> out_valid at N+3 with a ready memory and 1-cycle response.
// Backpressure: single outstanding op; in_ready low in REQ/WAIT/RESP, request held until
//          mem_req_ready, result held until out_ready.
// Ports: clk/rst_n (async active-low); in_* execute op (valid/ready); mem_req_* request
//        (valid/ready); mem_resp_* response/write-ack; out_* writeback result (valid/ready).
module lsu_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_err,
    output logic [1:0]  out_err_code
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TO_LIM     = 8'(TIMEOUT_CYC);
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ALIGN  = 2'b01;
    localparam logic [1:0] ERR_TMO    = 2'b10;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        req_vld_q, req_vld_d;
    logic        req_we_q, req_we_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_mask_q, req_mask_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        out_vld_q, out_vld_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_err_q, out_err_d;
    logic [1:0]  out_code_q, out_code_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        misalign;
    logic [3:0]  acc_mask;
    logic [31:0] acc_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    // Decode of the incoming op: alignment fault, byte lanes and lane-shifted store data.
    always_comb begin
        misalign = 1'b0;
        case (in_funct3)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = in_addr[0];
            3'b010:         misalign = |in_addr[1:0];
            default:        misalign = 1'b1;   // reserved encodings fault like misalignment
        endcase

        acc_mask = 4'b0000;
        case (in_funct3[1:0])
            2'b00:   acc_mask = 4'b0001 << in_addr[1:0];
            2'b01:   acc_mask = 4'b0011 << in_addr[1:0];
            default: acc_mask = 4'b1111;
        endcase

        acc_wdata = in_wdata << {in_addr[1:0], 3'b000};
    end

    // Load data extraction uses the offset/funct3 captured at accept, not the live inputs.
    always_comb begin
        ld_shift = mem_resp_data >> {off_q, 3'b000};
        ld_ext   = ld_shift;
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        req_vld_d   = req_vld_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_mask_d  = req_mask_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_code_d  = out_code_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && (in_is_load || in_is_store)) begin
                    funct3_d   = in_funct3;
                    off_d      = in_addr[1:0];
                    rd_d       = in_rd;
                    in_ready_d = 1'b0;
                    if (misalign) begin
                        // Fault is reported directly; memory never sees this op.
                        state_d    = S_RESP;
                        out_vld_d  = 1'b1;
                        out_data_d = 32'h0;
                        out_err_d  = 1'b1;
                        out_code_d = ERR_ALIGN;
                    end else begin
                        state_d     = S_REQ;
                        req_vld_d   = 1'b1;
                        req_we_d    = in_is_store;
                        req_addr_d  = {in_addr[31:2], 2'b00};
                        req_wdata_d = in_is_store ? acc_wdata : 32'h0;
                        req_mask_d  = in_is_store ? acc_mask : 4'b0000;
                        out_err_d   = 1'b0;
                        out_code_d  = ERR_NONE;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d   = S_WAIT;
                    req_vld_d = 1'b0;
                    cnt_d     = 8'h0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A response in the final allowed cycle beats the timeout.
                if (mem_resp_valid) begin
                    state_d    = S_RESP;
                    out_vld_d  = 1'b1;
                    out_data_d = req_we_q ? 32'h0 : ld_ext;
                    out_err_d  = 1'b0;
                    out_code_d = ERR_NONE;
                end else if (cnt_d == TO_LIM) begin
                    state_d    = S_RESP;
                    out_vld_d  = 1'b1;
                    out_data_d = 32'h0;
                    out_err_d  = 1'b1;
                    out_code_d = ERR_TMO;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    out_vld_d  = 1'b0;
                    in_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
                req_vld_d  = 1'b0;
                out_vld_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            req_vld_q   <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            req_mask_q  <= 4'h0;
            funct3_q    <= 3'h0;
            off_q       <= 2'h0;
            rd_q        <= 5'h0;
            out_vld_q   <= 1'b0;
            out_data_q  <= 32'h0;
            out_err_q   <= 1'b0;
            out_code_q  <= ERR_NONE;
            cnt_q       <= 8'h0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            req_vld_q   <= req_vld_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_mask_q  <= req_mask_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_code_q  <= out_code_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = req_vld_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = {4'h0, req_mask_q};
    assign out_valid     = out_vld_q;
    assign out_data      = out_data_q;
    assign out_rd        = rd_q;
    assign out_err       = out_err_q;
    assign out_err_code  = out_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Purpose: self-checking bench for lsu_ctrl (TIMEOUT_CYC=4): vector table plus reset sequence.
// Latency: checks accept-to-out_valid cycle counts per vector.
// Backpressure: exercises request stalls, output stalls and ignored inputs while busy.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_err;
    logic [1:0]  out_err_code;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_err(out_err), .out_err_code(out_err_code)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // resp_dly: WAIT cycle (1-based) in which the response is returned; 0 = never.
    typedef struct {
        string       name;
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          req_dly;
        int          resp_dly;
        int          out_dly;
        logic [31:0] resp_data;
        bit          exp_req;
        logic [7:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [1:0]  exp_code;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    function automatic vec_t mk(input string name, input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                                input int req_dly, input int resp_dly, input int out_dly,
                                input logic [31:0] resp_data, input bit exp_req, input logic [7:0] exp_mask,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                                input logic exp_err, input logic [1:0] exp_code, input int exp_lat);
        vec_t v;
        v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.req_dly = req_dly; v.resp_dly = resp_dly; v.out_dly = out_dly; v.resp_data = resp_data;
        v.exp_req = exp_req; v.exp_mask = exp_mask; v.exp_wdata = exp_wdata; v.exp_data = exp_data;
        v.exp_err = exp_err; v.exp_code = exp_code; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 1);
        chk({pfx, "_req_valid"}, mem_req_valid, 0);
        chk({pfx, "_req_fields"}, {mem_req_we, mem_req_wmask}, 0);
        chk({pfx, "_req_addr"}, mem_req_addr, 0);
        chk({pfx, "_req_wdata"}, mem_req_wdata, 0);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_out_data"}, out_data, 0);
        chk({pfx, "_out_rd_err"}, {out_rd, out_err, out_err_code}, 0);
    endtask

    task automatic do_op(input vec_t v);
        int   c;
        int   rq;
        int   wcnt;
        int   hold;
        bit   done, waiting, req_seen, spurious, busy_ok, out_seen, released;
        exp_t e;

        c = 0;
        while (!in_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk({v.name, "_idle_ready"}, in_ready, 1);

        in_valid = 1'b1; in_is_load = v.ld; in_is_store = v.st; in_funct3 = v.f3;
        in_addr = v.addr; in_wdata = v.wdata; in_rd = v.rd;
        e.data = v.exp_data; e.rd = v.rd; e.err = v.exp_err; e.code = v.exp_code;
        sb.push_back(e);
        @(negedge clk);
        // Scramble the operand inputs while busy; the DUT must ignore them.
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        in_rd = 5'($urandom); in_funct3 = 3'($urandom_range(0, 7));

        done = 0; waiting = 0; req_seen = 0; spurious = 0; busy_ok = 1;
        out_seen = 0; released = 0; rq = 0; wcnt = 0; hold = 0;
        for (c = 1; c < 60 && !done; c++) begin
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
            if (released) begin
                chk({v.name, "_out_drop"}, out_valid, 0);
                chk({v.name, "_ready_back"}, in_ready, 1);
                done = 1;
            end else begin
                if (in_ready) busy_ok = 0;
                if (out_valid) begin
                    if (!out_seen) begin
                        out_seen = 1;
                        chk({v.name, "_latency"}, c, v.exp_lat);
                        if (sb.size() == 0) begin
                            chk({v.name, "_sb_nonempty"}, 0, 1);
                        end else begin
                            e = sb.pop_front();
                            chk({v.name, "_out_data"}, out_data, e.data);
                            chk({v.name, "_out_rd"}, out_rd, e.rd);
                            chk({v.name, "_out_err"}, {out_err, out_err_code}, {e.err, e.code});
                        end
                    end else begin
                        chk({v.name, "_out_hold"}, {out_data, 3'b0, out_rd, 21'b0, out_err, out_err_code},
                            {e.data, 3'b0, e.rd, 21'b0, e.err, e.code});
                    end
                    if (hold == v.out_dly) begin
                        out_ready = 1'b1;
                        released  = 1;
                    end
                    hold++;
                end else if (mem_req_valid) begin
                    if (!v.exp_req) begin
                        spurious = 1;
                    end else begin
                        if (!req_seen) begin
                            chk({v.name, "_req_addr"}, mem_req_addr, {v.addr[31:2], 2'b00});
                            chk({v.name, "_req_we"}, mem_req_we, v.st);
                            chk({v.name, "_req_mask"}, mem_req_wmask, v.exp_mask);
                            if (v.st) chk({v.name, "_req_wdata"}, mem_req_wdata, v.exp_wdata);
                        end else begin
                            chk({v.name, "_req_hold"}, {mem_req_addr, mem_req_wmask, 7'b0, mem_req_we},
                                {v.addr[31:2], 2'b00, v.exp_mask, 7'b0, v.st});
                        end
                        req_seen = 1;
                        if (rq == v.req_dly) begin
                            mem_req_ready = 1'b1;
                            waiting = 1;
                        end else begin
                            // Stray response while still requesting must be ignored.
                            mem_resp_valid = 1'b1;
                            mem_resp_data  = $urandom;
                        end
                        rq++;
                    end
                end else if (waiting) begin
                    wcnt++;
                    if (wcnt == v.resp_dly) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = v.resp_data;
                    end
                end
            end
            if (!done) @(negedge clk);
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
        chk({v.name, "_completed"}, done, 1);
        chk({v.name, "_busy_in_ready_low"}, busy_ok, 1);
        if (v.exp_req) chk({v.name, "_req_seen"}, req_seen, 1);
        else           chk({v.name, "_no_req"}, spurious, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        //              name     ld st f3      addr          wdata         rd  rqd rsd od resp_data     req mask   exp_wdata     exp_data      err code lat
        vecs[0]  = mk("lb_neg", 1, 0, 3'b000, 32'h8000_0003, 32'h0,        5,  0,  1,  0, 32'h8012_3456, 1, 8'h00, 32'h0,        32'hFFFF_FF80, 0, 2'b00, 3);
        vecs[1]  = mk("sh",     0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 0,  0,  1,  1, 32'h0,        1, 8'h0C, 32'hBEEF_0000, 32'h0,        0, 2'b00, 3);
        vecs[2]  = mk("lw_mis", 1, 0, 3'b010, 32'h8000_0001, 32'h0,        9,  0,  1,  2, 32'h0,        0, 8'h00, 32'h0,        32'h0,        1, 2'b01, 1);
        vecs[3]  = mk("lhu_stl",1, 0, 3'b101, 32'h8000_0002, 32'h0,        17, 5,  2,  0, 32'hA5A5_1234, 1, 8'h00, 32'h0,        32'h0000_A5A5, 0, 2'b00, 9);
        vecs[4]  = mk("lw_tmo", 1, 0, 3'b010, 32'h1000_0004, 32'h0,        3,  0,  0,  0, 32'h0,        1, 8'h00, 32'h0,        32'h0,        1, 2'b10, 6);
        vecs[5]  = mk("lw_edge",1, 0, 3'b010, 32'h1000_0008, 32'h0,        4,  0,  4,  0, 32'hDEAD_BEEF, 1, 8'h00, 32'h0,        32'hDEAD_BEEF, 0, 2'b00, 6);
        vecs[6]  = mk("lbu",    1, 0, 3'b100, 32'h0000_0001, 32'h0,        6,  1,  3,  0, 32'h1234_FE78, 1, 8'h00, 32'h0,        32'h0000_00FE, 0, 2'b00, 6);
        vecs[7]  = mk("lh_neg", 1, 0, 3'b001, 32'h0000_0042, 32'h0,        7,  0,  1,  0, 32'h8001_0000, 1, 8'h00, 32'h0,        32'hFFFF_8001, 0, 2'b00, 3);
        vecs[8]  = mk("sb_b3",  0, 1, 3'b000, 32'h0000_0003, 32'h0000_00AB, 8,  0,  2,  0, 32'h0,        1, 8'h08, 32'hAB00_0000, 32'h0,        0, 2'b00, 4);
        vecs[9]  = mk("rsvd",   1, 0, 3'b011, 32'h0000_0000, 32'h0,        10, 0,  1,  0, 32'h0,        0, 8'h00, 32'h0,        32'h0,        1, 2'b01, 1);
        vecs[10] = mk("sw_post",0, 1, 3'b010, 32'h0000_0000, 32'h1122_3344, 11, 0,  1,  0, 32'h0,        1, 8'h0F, 32'h1122_3344, 32'h0,        0, 2'b00, 3);

        rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b0;
        in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        // Valid with neither load nor store is dropped.
        in_valid = 1'b1; in_addr = 32'h1234_5678;
        @(negedge clk);
        in_valid = 1'b0;
        chk("nop_in_ready", in_ready, 1);
        chk("nop_no_req", mem_req_valid, 0);
        chk("nop_no_out", out_valid, 0);

        for (int i = 0; i < 10; i++) do_op(vecs[i]);

        // Reset asserted mid-WAIT clears everything before the next clock edge.
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
        in_addr = 32'h0000_0100; in_rd = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("mid_req_drop", mem_req_valid, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_async");
        @(negedge clk);
        chk("rst_no_out", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(vecs[10]);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage between execute and the physical-memory access stage.
- Accepts one memory op at a time from execute and checks alignment.
- Drives a word-aligned request with byte mask to the memory side, waits for the response, and returns the shifted, sign/zero-extended load result to writeback.
- Single outstanding transaction; blocks upstream while busy.

Parameters:
TIMEOUT_CYC, 255, max cycles waiting for mem_resp_valid before a timeout error (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  execute presents an op
in_ready  out  1  stage can accept an op
in_is_load  in  1  op is a load
in_is_store  in  1  op is a store (never both set with in_is_load)
in_funct3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
in_addr  in  32  byte address
in_wdata  in  32  store data, LSB-justified
in_rd  in  5  destination register tag
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write
mem_req_addr  out  32  in_addr with [1:0] forced to 0
mem_req_wdata  out  32  store data shifted to byte lane
mem_req_wmask  out  8  byte-enable; [3:0] lanes, [7:4] always 0
mem_resp_valid  in  1  response / write-ack valid
mem_resp_data  in  32  raw aligned read word
out_valid  out  1  result to writeback valid
out_ready  in  1  writeback accepts
out_data  out  32  extended load data; 0 for stores and errors
out_rd  out  5  captured in_rd
out_err  out  1  op faulted
out_err_code  out  2  01 misaligned, 10 timeout, 00 none

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready=1; mem_req_valid=0; out_valid=0; out_data=0; out_rd=0; out_err=0; out_err_code=0; mem_req_* data outputs=0; timeout counter=0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid with neither load nor store: ignore and stay IDLE.
- IDLE, on in_valid && (load || store): capture addr, funct3, rd, we, shifted wdata, mask.
  - Misaligned (h/hu with addr[0]=1, w with addr[1:0]!=0, reserved funct3) -> RESP with out_err=1, code 01, no memory request.
  - Otherwise -> REQ.
- Mask per offset o=addr[1:0]: byte 1<<o; half 3<<o; word 0xF. wdata shifted left by 8*o. Loads drive mask 0.
- REQ: mem_req_valid=1 and all req fields stable until mem_req_ready. On the ready cycle -> WAIT with counter cleared. mem_req_valid drops the next cycle.
- WAIT: counter increments each cycle.
  - mem_resp_valid -> RESP. Loads register the extracted result: shift right by 8*o, then sign/zero-extend per funct3. Stores set out_data=0.
  - Counter reaching TIMEOUT_CYC without a response -> RESP, out_err=1, code 10, out_data=0.
  - Response and timeout in the same cycle: response wins.
- mem_resp_valid outside WAIT is ignored.
- RESP: out_valid=1, outputs held stable until out_ready. On out_ready -> IDLE with out_valid=0 the next cycle. No same-cycle accept of a new op, so minimum throughput is one op per 4 cycles.
- Latency with ready memory and a 1-cycle response: in accept cycle N -> out_valid at N+3.
- in_ready=0 in REQ/WAIT/RESP. in_* changes there are ignored.
- Reset mid-operation abandons the transaction immediately. Memory must tolerate a dropped request.

Test Plan:
- lb at 0x8000_0003, resp data 0x80_12_34_56 -> mem_req_addr 0x8000_0000, wmask 0x00, out_data 0xFFFF_FF80, out_err 0.
- sh at 0x8000_0002, wdata 0x0000_BEEF -> mem_req_we 1, wmask 0x0C, wdata 0xBEEF_0000; after ack out_valid, out_data 0.
- lw at 0x8000_0001 -> no mem_req_valid ever; out_valid with out_err 1, code 01, out_rd = captured rd.
- lhu at 0x8000_0002, mem_req_ready low 5 cycles, resp 0xA5A5_1234 -> request held stable for 5 cycles, out_data 0x0000_A5A5.
- TIMEOUT_CYC=4, load with no response -> out_err 1, code 10 on the 4th WAIT cycle; response arriving exactly then gives out_err 0 instead.
- rst_n low during WAIT -> all outputs at reset values asynchronously; a following sw at 0x0 completes normally with wmask 0x0F.
